// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, fill-count type and mask helpers for the SPI rx packer
package spi_pkg;
  localparam int MAX_WORD_SIZE = 16;
  localparam int OUT_WIDTH = 32;
  localparam int ACC_WIDTH = OUT_WIDTH + MAX_WORD_SIZE;
  localparam int FILL_WIDTH = $clog2(ACC_WIDTH);
  localparam int KEEP_WIDTH = OUT_WIDTH / 8;
  localparam int WS_WIDTH = $clog2(MAX_WORD_SIZE);
  typedef logic [FILL_WIDTH-1:0] fill_t;
  function automatic logic [KEEP_WIDTH-1:0] keep_from_fill(fill_t fill);
    int bytes;
    bytes = (int'(fill) + 7) / 8;
    return KEEP_WIDTH'((64'd1 << bytes) - 64'd1);
  endfunction
  function automatic logic [MAX_WORD_SIZE-1:0] word_mask(logic [WS_WIDTH:0] width);
    return MAX_WORD_SIZE'((64'd1 << width) - 64'd1);
  endfunction
endpackage

// File: rtl/spi_bit_accumulator.sv
// spi_bit_accumulator: LSB-first bit accumulator with masked insert and shift-out of full beats
// clock/reset: async active-high reset; clear: synchronous wipe; pop: insert word;
// emit: drop the low OUT_WIDTH bits; width: frame width 1..MAX_WORD_SIZE; acc/fill: state.
module spi_bit_accumulator
  import spi_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     pop,
  input  logic                     emit,
  input  logic [MAX_WORD_SIZE-1:0] word,
  input  logic [WS_WIDTH:0]        width,
  output logic [ACC_WIDTH-1:0]     acc,
  output fill_t                    fill
);
  logic [ACC_WIDTH-1:0] acc_s;
  fill_t fill_s;
  // a word popped in the same cycle as an emit lands at the post-shift position
  always_comb begin
    acc_s = emit ? acc >> OUT_WIDTH : acc;
    fill_s = emit ? fill - fill_t'(OUT_WIDTH) : fill;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      acc <= '0;
      fill <= '0;
    end else if (clear) begin
      acc <= '0;
      fill <= '0;
    end else if (pop) begin
      acc <= acc_s | (ACC_WIDTH'(word & word_mask(width)) << fill_s);
      fill <= fill_s + fill_t'(width);
    end else begin
      acc <= acc_s;
      fill <= fill_s;
    end
endmodule

// File: rtl/spi_rx_packer.sv
// spi_rx_packer: packs SPI rx FIFO frames LSB-first into keep/last-marked stream beats
// clock/reset: async active-high reset; enable: low clears and samples wordSize (width-1);
// rxData/emptyRxFifo/pop: show-ahead FIFO read side; flush: close packet, flushDone on completion;
// outData/outKeep/outLast/outValid/outReady: output beat stream.
module spi_rx_packer
  import spi_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [WS_WIDTH-1:0]      wordSize,
  input  logic [MAX_WORD_SIZE-1:0] rxData,
  input  logic                     emptyRxFifo,
  output logic                     pop,
  input  logic                     flush,
  output logic [OUT_WIDTH-1:0]     outData,
  output logic [KEEP_WIDTH-1:0]    outKeep,
  output logic                     outLast,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     flushDone
);
  logic [WS_WIDTH-1:0] ws_reg;
  logic [WS_WIDTH:0] width;
  logic pend_flush, reg_free, full, emit, flush_ok, drain, mark_last, flush_end;
  logic [ACC_WIDTH-1:0] acc;
  fill_t fill;
  // flush_ok: nothing more can arrive, so the packet tail is whatever sits in acc
  // drain: emit the partial beat; mark_last: tag the held beat when acc is empty
  always_comb begin
    width = {1'b0, ws_reg} + (WS_WIDTH+1)'(1);
    reg_free = !outValid || outReady;
    full = fill >= fill_t'(OUT_WIDTH);
    pop = enable && !reset && !emptyRxFifo && !full;
    emit = enable && full && reg_free;
    flush_ok = enable && pend_flush && emptyRxFifo && !pop && !full;
    drain = flush_ok && fill != '0 && reg_free;
    mark_last = flush_ok && fill == '0 && outValid && !outReady;
    flush_end = flush_ok && (fill == '0 || reg_free);
  end
  spi_bit_accumulator u_acc (
    .clock(clock),
    .reset(reset),
    .clear(!enable || drain),
    .pop  (pop),
    .emit (emit),
    .word (rxData),
    .width(width),
    .acc  (acc),
    .fill (fill)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ws_reg <= '0;
      pend_flush <= 1'b0;
      outData <= '0;
      outKeep <= '0;
      outLast <= 1'b0;
      outValid <= 1'b0;
      flushDone <= 1'b0;
    end else if (!enable) begin
      ws_reg <= wordSize;
      pend_flush <= 1'b0;
      outData <= '0;
      outKeep <= '0;
      outLast <= 1'b0;
      outValid <= 1'b0;
      flushDone <= 1'b0;
    end else begin
      pend_flush <= !flush_end && (pend_flush || flush);
      flushDone <= flush_end;
      if (emit || drain) begin
        outData <= acc[OUT_WIDTH-1:0];
        outKeep <= emit ? '1 : keep_from_fill(fill);
        outLast <= drain;
        outValid <= 1'b1;
      end else if (mark_last) outLast <= 1'b1;
      else if (outReady) outValid <= 1'b0;
    end
endmodule
